// File: rtl/tw_rom2_pkg.sv
// ============================================================================
// Module      : tw_rom2_pkg
// Description : Shared constants and types for the twiddle ROM2 loader and the
//               ROM side that consumes its write stream: word widths, burst
//               length, ROM2_w write codes and the loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tw_rom2_pkg;

  // Word geometry: one twiddle entry carries two packed 64-bit constants.
  localparam int c_P_WIDTH          = 128;
  localparam int c_HDW              = 64;
  localparam int c_INIT_STORE_DATA  = 4;

  // ROM2_w codes seen by the ROM side; 2'd3 is reserved and never driven.
  localparam logic [1:0] c_ROM2W_IDLE = 2'd0;
  localparam logic [1:0] c_ROM2W_HI   = 2'd1;
  localparam logic [1:0] c_ROM2W_LO   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_SEND_HI = 3'd2,
    ST_SEND_LO = 3'd3,
    ST_DONE    = 3'd4
  } tw_state_e;

endpackage

`default_nettype wire

// File: rtl/tw_rom2_ld_buf.sv
// ============================================================================
// Module      : tw_rom2_ld_buf
// Description : DEPTH x P_WIDTH entry store for one load burst. One synchronous
//               write port (index + data) and one asynchronous read port
//               (index + half select, hi = upper HDW bits).
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               i_wr_en/idx/data  - write port
//               i_rd_idx, i_rd_hi - read index and half select
//               o_rd_data         - selected half of the indexed entry
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tw_rom2_ld_buf
  import tw_rom2_pkg::*;
#(
  parameter int P_WIDTH = c_P_WIDTH,
  parameter int HDW     = c_HDW,
  parameter int DEPTH   = c_INIT_STORE_DATA,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [P_WIDTH-1:0] i_wr_data,
  input  logic [IDX_W-1:0]   i_rd_idx,
  input  logic               i_rd_hi,
  output logic [HDW-1:0]     o_rd_data
);

  logic [P_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = i_rd_hi ? r_mem[i_rd_idx][P_WIDTH-1 -: HDW]
                             : r_mem[i_rd_idx][HDW-1:0];

endmodule

`default_nettype wire

// File: rtl/tw_rom2_loader.sv
// ============================================================================
// Module      : tw_rom2_loader
// Description : Collects one burst of twiddle entries, then streams all high
//               halves (ROM2_w=1) followed by all low halves (ROM2_w=2) to the
//               ROM side, then pulses done. Outputs decode registered state
//               only; no input reaches an output combinationally.
// Ports       : CLK, rst_n           - clock, synchronous active-low reset
//               start                - begins a burst (honoured in IDLE only)
//               in_valid/in_data/in_ready - entry handshake
//               horizontal_row0_out  - high-half stream
//               horizontal_row1_out  - low-half stream
//               ROM2_w               - 0 idle, 1 high write, 2 low write
//               busy, done           - burst status
//               abort                - only with TW_ROM2_LOADER_ABORT_EN
// Config      : TW_ROM2_LOADER_ABORT_EN adds the abort input; buffer contents
//               survive an abort.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tw_rom2_loader
  import tw_rom2_pkg::*;
#(
  parameter int P_WIDTH         = c_P_WIDTH,
  parameter int horizontal_DW   = c_HDW,
  parameter int init_store_data = c_INIT_STORE_DATA
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     start,
`ifdef TW_ROM2_LOADER_ABORT_EN
  input  logic                     abort,
`endif
  input  logic                     in_valid,
  input  logic [P_WIDTH-1:0]       in_data,
  output logic                     in_ready,
  output logic [horizontal_DW-1:0] horizontal_row0_out,
  output logic [horizontal_DW-1:0] horizontal_row1_out,
  output logic [1:0]               ROM2_w,
  output logic                     busy,
  output logic                     done
);

  localparam int               c_IDX_W = $clog2(init_store_data);
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(init_store_data - 1);

  tw_state_e             r_state;
  tw_state_e             w_state_nxt;
  logic [c_IDX_W-1:0]    r_wr_cnt;
  logic [c_IDX_W-1:0]    r_send_cnt;
  logic                  w_accept;
  logic                  w_sending;
  logic                  w_send_last;
  logic                  w_abort;
  logic [horizontal_DW-1:0] w_rd_data;

  assign w_accept    = in_valid && (r_state == ST_COLLECT);
  assign w_sending   = (r_state == ST_SEND_HI) || (r_state == ST_SEND_LO);
  assign w_send_last = (r_send_cnt == c_LAST);

`ifdef TW_ROM2_LOADER_ABORT_EN
  assign w_abort = abort && (r_state != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  tw_rom2_ld_buf #(
    .P_WIDTH (P_WIDTH),
    .HDW     (horizontal_DW),
    .DEPTH   (init_store_data)
  ) u_buf (
    .clk       (CLK),
    .rst_n     (rst_n),
    .i_wr_en   (w_accept && !w_abort),
    .i_wr_idx  (r_wr_cnt),
    .i_wr_data (in_data),
    .i_rd_idx  (r_send_cnt),
    .i_rd_hi   (r_state == ST_SEND_HI),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The send counter wraps on the last high half so the low-half pass starts
  // at slot 0 again, keeping the ROM side's slot index aligned.
  always_ff @(posedge CLK) begin
    if (!rst_n || w_abort) begin
      r_wr_cnt   <= '0;
      r_send_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_wr_cnt <= (r_wr_cnt == c_LAST) ? '0 : r_wr_cnt + 1'b1;
      end
      if (w_sending) begin
        r_send_cnt <= w_send_last ? '0 : r_send_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    ROM2_w              = c_ROM2W_IDLE;
    horizontal_row0_out = '0;
    horizontal_row1_out = '0;
    in_ready            = 1'b0;
    busy                = 1'b1;
    done                = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && (r_wr_cnt == c_LAST)) w_state_nxt = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        ROM2_w              = c_ROM2W_HI;
        horizontal_row0_out = w_rd_data;
        if (w_send_last) w_state_nxt = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        ROM2_w              = c_ROM2W_LO;
        horizontal_row1_out = w_rd_data;
        if (w_send_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_abort) w_state_nxt = ST_IDLE;
  end

endmodule

`default_nettype wire

// File: tb/tb_tw_rom2_loader.sv
// ============================================================================
// Module      : tb_tw_rom2_loader
// Description : Self-checking bench for tw_rom2_loader. A burst-level model
//               (phase + 8-slot output schedule) predicts every output each
//               cycle; directed scenarios add literal timing/data expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tw_rom2_loader;

  logic         CLK = 1'b0;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic [63:0]  row0;
  logic [63:0]  row1;
  logic [1:0]   ROM2_w;
  logic         busy;
  logic         done;
`ifdef TW_ROM2_LOADER_ABORT_EN
  logic         abort = 1'b0;
`endif

  always #5 CLK = ~CLK;

  tw_rom2_loader dut (
    .CLK                 (CLK),
    .rst_n               (rst_n),
    .start               (start),
`ifdef TW_ROM2_LOADER_ABORT_EN
    .abort               (abort),
`endif
    .in_valid            (in_valid),
    .in_data             (in_data),
    .in_ready            (in_ready),
    .horizontal_row0_out (row0),
    .horizontal_row1_out (row1),
    .ROM2_w              (ROM2_w),
    .busy                (busy),
    .done                (done)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_COLLECT = 1, P_SEND = 2, P_DONE = 3;
  int           m_phase = P_IDLE;
  int           m_n     = 0;
  int           m_pos   = 0;
  bit           m_valid = 1'b0;
  logic [127:0] m_ent [4];

  always @(posedge CLK) begin
    cyc++;
    if (!rst_n) begin
      m_phase = P_IDLE; m_n = 0; m_pos = 0; m_valid = 1'b1;
      for (int i = 0; i < 4; i++) m_ent[i] = '0;
    end
`ifdef TW_ROM2_LOADER_ABORT_EN
    else if (abort && m_phase != P_IDLE) begin
      m_phase = P_IDLE; m_n = 0; m_pos = 0;
    end
`endif
    else begin
      case (m_phase)
        P_IDLE:    if (start) begin m_phase = P_COLLECT; m_n = 0; end
        P_COLLECT: if (in_valid) begin
                     m_ent[m_n] = in_data;
                     m_n++;
                     if (m_n == 4) begin m_phase = P_SEND; m_pos = 0; end
                   end
        P_SEND:    begin m_pos++; if (m_pos == 8) m_phase = P_DONE; end
        default:   m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- compare + capture ----------------
  logic [63:0] q_hi [$];
  logic [63:0] q_lo [$];
  int first_hi_cyc = -1;
  int last_w_cyc   = -1;
  int min_gap      = 1000;

  always @(negedge CLK) begin
    if (m_valid) begin
      logic [1:0]  ew;
      logic [63:0] e0, e1;
      ew = 2'd0; e0 = '0; e1 = '0;
      if (m_phase == P_SEND) begin
        if (m_pos < 4) begin ew = 2'd1; e0 = m_ent[m_pos][127:64]; end
        else           begin ew = 2'd2; e1 = m_ent[m_pos-4][63:0]; end
      end
      check("ROM2_w",   ROM2_w,   ew);
      check("row0",     row0,     e0);
      check("row1",     row1,     e1);
      check("in_ready", in_ready, (m_phase == P_COLLECT));
      check("busy",     busy,     (m_phase != P_IDLE));
      check("done",     done,     (m_phase == P_DONE));
    end
    if (ROM2_w == 2'd1) begin
      if (q_hi.size() == 0) first_hi_cyc = cyc;
      q_hi.push_back(row0);
    end
    if (ROM2_w == 2'd2) q_lo.push_back(row1);
    if (ROM2_w != 2'd0) begin
      if (last_w_cyc >= 0 && cyc - last_w_cyc - 1 > 0 && cyc - last_w_cyc - 1 < min_gap)
        min_gap = cyc - last_w_cyc - 1;
      last_w_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  logic [127:0] ent [4];

  task automatic clear_logs();
    q_hi.delete(); q_lo.delete(); first_hi_cyc = -1;
  endtask

  task automatic burst(input int stall_after, input int stall_len, input bit start_in_lo,
                       output int t0, output int tdone);
    bit got;
    @(negedge CLK); start = 1'b1; t0 = cyc;
    @(negedge CLK); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = ent[i];
      @(negedge CLK);
      if (i == stall_after) begin
        in_valid = 1'b0;
        repeat (stall_len) @(negedge CLK);
      end
    end
    in_valid = 1'b0;
    got = 1'b0; tdone = -1;
    for (int k = 0; k < 40; k++) begin
      if (start_in_lo) start = (cyc == t0 + 10);
      if (done) begin got = 1'b1; tdone = cyc; break; end
      @(negedge CLK);
    end
    start = 1'b0;
    check("done_seen", got, 1'b1);
  endtask

  task automatic check_stream(input string nm);
    check({nm, "_hi_cnt"}, q_hi.size(), 4);
    check({nm, "_lo_cnt"}, q_lo.size(), 4);
    for (int i = 0; i < 4 && i < q_hi.size() && i < q_lo.size(); i++) begin
      check({nm, "_hi"}, q_hi[i], ent[i][127:64]);
      check({nm, "_lo"}, q_lo[i], ent[i][63:0]);
    end
  endtask

  initial begin
    int t0, td, t0b, tdb;
    bit seen;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge CLK);
    check("rst_ROM2_w", ROM2_w, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge CLK);

    // Nominal burst with literal expectations.
    ent[0] = 128'h0000000000000001_0000000000000001;
    ent[1] = 128'hfff7ffff00000001_969e9096afde4510;
    ent[2] = 128'hfffffffeffffffc1_007fffffffffff80;
    ent[3] = 128'h0200000000000000_840fa37ec53a39e1;
    clear_logs();
    burst(-1, 0, 1'b0, t0, td);
    check("nom_first_hi", first_hi_cyc - t0, 5);
    check("nom_done_lat", td - t0, 13);
    check("nom_hi_cnt", q_hi.size(), 4);
    check("nom_lo_cnt", q_lo.size(), 4);
    if (q_hi.size() == 4 && q_lo.size() == 4) begin
      check("nom_hi0", q_hi[0], 64'h0000000000000001);
      check("nom_hi1", q_hi[1], 64'hfff7ffff00000001);
      check("nom_hi2", q_hi[2], 64'hfffffffeffffffc1);
      check("nom_hi3", q_hi[3], 64'h0200000000000000);
      check("nom_lo0", q_lo[0], 64'h0000000000000001);
      check("nom_lo1", q_lo[1], 64'h969e9096afde4510);
      check("nom_lo2", q_lo[2], 64'h007fffffffffff80);
      check("nom_lo3", q_lo[3], 64'h840fa37ec53a39e1);
    end

    // Back-to-back burst: start the cycle right after done.
    for (int i = 0; i < 4; i++) ent[i] = {32'hA5A50000 + i, 32'h1111 * (i + 1), 32'hC3C30000 + i, 32'h7777 * (i + 1)};
    clear_logs();
    burst(-1, 0, 1'b0, t0b, tdb);
    check("b2b_start", t0b - td, 1);
    check("b2b_done_lat", tdb - t0b, 13);
    check_stream("b2b");

    // Stall of 3 cycles after entry 1.
    for (int i = 0; i < 4; i++) ent[i] = {64'h0123456789abcdef ^ (64'h1 << i), 64'hfedcba9876543210 + i};
    clear_logs();
    burst(1, 3, 1'b0, t0, td);
    check("stall_first_hi", first_hi_cyc - t0, 8);
    check("stall_done_lat", td - t0, 16);
    check_stream("stall");

    // in_valid in IDLE is ignored; start during SEND_LO is ignored.
    @(negedge CLK);
    in_valid = 1'b1; in_data = {128{1'b1}};
    repeat (4) begin
      @(negedge CLK);
      check("idle_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) ent[i] = {32'h0, 32'h10 + i, 32'hffff0000, 32'h20 + i};
    clear_logs();
    burst(-1, 0, 1'b1, t0, td);
    check("ign_done_lat", td - t0, 13);
    check_stream("ign");
    seen = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (ROM2_w != 2'd0 || busy) seen = 1'b1;
    end
    check("ign_no_extra", seen, 1'b0);

    // Reset on the 2nd SEND_HI cycle.
    clear_logs();
    @(negedge CLK); start = 1'b1; t0 = cyc;
    @(negedge CLK); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = ent[i];
      @(negedge CLK);
    end
    in_valid = 1'b0;
    @(negedge CLK);
    rst_n = 1'b0;
    @(negedge CLK);
    check("rstmid_ROM2_w", ROM2_w, 2'd0);
    check("rstmid_busy", busy, 1'b0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    check("rstmid_no_done", seen, 1'b0);
    check("rstmid_hi_cnt", q_hi.size(), 2);
    check("rstmid_lo_cnt", q_lo.size(), 0);
    for (int i = 0; i < 4; i++) ent[i] = {64'h8000000000000000 >> i, 64'h1 << (i * 7)};
    clear_logs();
    burst(-1, 0, 1'b0, t0, td);
    check("rstmid_done_lat", td - t0, 13);
    check_stream("rstmid");

`ifdef TW_ROM2_LOADER_ABORT_EN
    // Abort in COLLECT after 2 entries.
    clear_logs();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 128'hdead;
      @(negedge CLK);
    end
    in_valid = 1'b0; abort = 1'b1;
    @(negedge CLK); abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    repeat (5) @(negedge CLK);
    check("abort_no_w", q_hi.size() + q_lo.size(), 0);
    for (int i = 0; i < 4; i++) ent[i] = {64'h5a5a5a5a00000000 + i, 64'h00000000a5a5a5a5 + i};
    burst(-1, 0, 1'b0, t0, td);
    check("abort_done_lat", td - t0, 13);
    check_stream("abort");
`endif

    check("min_gap_ge2", (min_gap >= 2 && min_gap < 1000), 1'b1);
    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
